alu_result_monitor: RTL and testbench

ALU_RESULT_MONITOR -- requirements
Module: alu_result_monitor

---
 rtl/alu_result_monitor.sv | 179 +++++++++++++++++
 tb/tb_alu_result_monitor.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_monitor.sv
`default_nettype none
// ============================================================================
// Module      : alu_result_monitor
// Description : Two-stage checker that compares the result of an ALU under
//               test against a golden-model result. Every compared
//               transaction is counted; mismatches are counted and their
//               full record is queued in a small FIFO for a consumer to drain.
//               Records that arrive while the FIFO is full and nothing is
//               popped are dropped, and the drop is reported through a
//               sticky overflow flag.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   n      : operand/result width
//   DEPTH  : error-record FIFO depth (power of two, >= 2)
//   CNT_W  : width of the check and error counters
// Ports
//   clk, rst_n            : clock; asynchronous active-low reset
//   in_valid              : transaction sample strobe
//   op, R2, R3            : opcode and operands of the transaction
//   R0                    : result produced by the ALU under test
//   ResultVerify          : expected result from the golden model
//   clear                 : synchronous flush (pipeline, counters, FIFO, flag)
//   err_valid / err_ready : record handshake (FIFO non-empty / consumer accept)
//   err_op .. err_exp     : head record fields, zero while err_valid=0
//   check_cnt, error_cnt  : saturating transaction / mismatch counters
//   overflow              : sticky, a mismatch record was dropped
// ============================================================================
module alu_result_monitor #(
  parameter int n     = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [2:0]       op,
  input  logic [n-1:0]     R2,
  input  logic [n-1:0]     R3,
  input  logic [n-1:0]     R0,
  input  logic [n-1:0]     ResultVerify,
  input  logic             clear,
  output logic             err_valid,
  input  logic             err_ready,
  output logic [2:0]       err_op,
  output logic [n-1:0]     err_R2,
  output logic [n-1:0]     err_R3,
  output logic [n-1:0]     err_R0,
  output logic [n-1:0]     err_exp,
  output logic [CNT_W-1:0] check_cnt,
  output logic [CNT_W-1:0] error_cnt,
  output logic             overflow
);

  // Pointers carry one extra bit so full and empty are distinguishable
  // without a separate occupancy register.
  localparam int                c_PTR_W    = $clog2(DEPTH);
  localparam int                c_REC_W    = 3 + 4 * n;
  localparam logic [c_PTR_W:0]  c_FULL_OCC = (c_PTR_W + 1)'(DEPTH);
  localparam logic [c_PTR_W:0]  c_PTR_ONE  = (c_PTR_W + 1)'(1);
  localparam logic [CNT_W-1:0]  c_CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  c_CNT_ONE  = CNT_W'(1);

  // --------------------------------------------------------------------------
  // Stage 1: registered copy of the sampled transaction
  // --------------------------------------------------------------------------
  logic             r_s1Valid;
  logic [2:0]       r_s1Op;
  logic [n-1:0]     r_s1R2;
  logic [n-1:0]     r_s1R3;
  logic [n-1:0]     r_s1R0;
  logic [n-1:0]     r_s1Exp;

  // --------------------------------------------------------------------------
  // Error-record FIFO and status
  // --------------------------------------------------------------------------
  logic [c_REC_W-1:0] r_fifoMem [DEPTH];
  logic [c_PTR_W:0]   r_wrPtr;
  logic [c_PTR_W:0]   r_rdPtr;
  logic [CNT_W-1:0]   r_checkCnt;
  logic [CNT_W-1:0]   r_errorCnt;
  logic               r_overflow;

  logic               w_mismatch;
  logic [c_PTR_W:0]   w_occupancy;
  logic               w_empty;
  logic               w_full;
  logic               w_pop;
  logic               w_push;
  logic               w_drop;
  logic [c_REC_W-1:0] w_headRec;

  // Full-width comparison; the opcode never masks result bits.
  assign w_mismatch  = r_s1Valid && (r_s1R0 != r_s1Exp);

  assign w_occupancy = r_wrPtr - r_rdPtr;
  assign w_empty     = (r_wrPtr == r_rdPtr);
  assign w_full      = (w_occupancy == c_FULL_OCC);

  // A pop on a full FIFO frees the slot the incoming record needs, so a
  // simultaneous push is accepted rather than dropped.
  assign w_pop       = !w_empty && err_ready;
  assign w_push      = w_mismatch && (!w_full || w_pop);
  assign w_drop      = w_mismatch && w_full && !w_pop;

  assign w_headRec   = r_fifoMem[r_rdPtr[c_PTR_W-1:0]];

  // Stage-1 payload carries no reset: it is only observed through r_s1Valid.
  always_ff @(posedge clk) begin
    if (in_valid && !clear) begin
      r_s1Op  <= op;
      r_s1R2  <= R2;
      r_s1R3  <= R3;
      r_s1R0  <= R0;
      r_s1Exp <= ResultVerify;
    end
  end

  // Record storage; stale entries are harmless because only the pointers
  // decide what is visible.
  always_ff @(posedge clk) begin
    if (w_push && !clear) begin
      r_fifoMem[r_wrPtr[c_PTR_W-1:0]] <= {r_s1Op, r_s1R2, r_s1R3, r_s1R0, r_s1Exp};
    end
  end

  // Control state: stage valid, pointers, counters and overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1Valid  <= 1'b0;
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_checkCnt <= '0;
      r_errorCnt <= '0;
      r_overflow <= 1'b0;
    end else if (clear) begin
      // Flush wins over any same-cycle sample, push or pop.
      r_s1Valid  <= 1'b0;
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_checkCnt <= '0;
      r_errorCnt <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_s1Valid <= in_valid;

      if (w_pop) begin
        r_rdPtr <= r_rdPtr + c_PTR_ONE;
      end
      if (w_push) begin
        r_wrPtr <= r_wrPtr + c_PTR_ONE;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end

      // Both counters hold at all-ones instead of wrapping.
      if (r_s1Valid && (r_checkCnt != c_CNT_MAX)) begin
        r_checkCnt <= r_checkCnt + c_CNT_ONE;
      end
      if (w_mismatch && (r_errorCnt != c_CNT_MAX)) begin
        r_errorCnt <= r_errorCnt + c_CNT_ONE;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: head record is gated so fields read zero when nothing is queued
  // (and therefore also immediately on reset).
  // --------------------------------------------------------------------------
  assign err_valid = !w_empty;
  assign {err_op, err_R2, err_R3, err_R0, err_exp} =
           err_valid ? w_headRec : {c_REC_W{1'b0}};
  assign check_cnt = r_checkCnt;
  assign error_cnt = r_errorCnt;
  assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_alu_result_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_result_monitor
// Description : Self-checking bench for alu_result_monitor. A queue-based
//               reference model tracks the expected records, counters and
//               overflow flag; directed scenarios cover the pass/fail cases,
//               overflow, full push+pop, saturation, reset and clear, followed
//               by randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_result_monitor;

  localparam int N     = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic [2:0]       op;
  logic [N-1:0]     R2, R3, R0, ResultVerify;
  logic             clear;
  logic             err_valid;
  logic             err_ready;
  logic [2:0]       err_op;
  logic [N-1:0]     err_R2, err_R3, err_R0, err_exp;
  logic [CNT_W-1:0] check_cnt, error_cnt;
  logic             overflow;

  alu_result_monitor #(.n(N), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .op(op),
    .R2(R2), .R3(R3), .R0(R0), .ResultVerify(ResultVerify),
    .clear(clear), .err_valid(err_valid), .err_ready(err_ready),
    .err_op(err_op), .err_R2(err_R2), .err_R3(err_R3), .err_R0(err_R0),
    .err_exp(err_exp), .check_cnt(check_cnt), .error_cnt(error_cnt),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Reference model: sampled transaction waiting one edge, then a plain queue
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [2:0]   op;
    logic [N-1:0] r2;
    logic [N-1:0] r3;
    logic [N-1:0] r0;
    logic [N-1:0] ex;
  } rec_t;

  rec_t mQ[$];
  int   mChk, mErr;
  bit   mOvf;
  bit   pendV;
  rec_t pend;

  int total = 0;
  int bad   = 0;

  task automatic chkVal(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, want);
    end
  endtask

  function automatic void modelReset();
    mQ.delete();
    mChk  = 0;
    mErr  = 0;
    mOvf  = 1'b0;
    pendV = 1'b0;
  endfunction

  // Called right after each rising edge, with the inputs seen at that edge.
  function automatic void modelStep();
    bit popNow;
    if (!rst_n || clear) begin
      modelReset();
      return;
    end
    popNow = (mQ.size() > 0) && err_ready;
    if (popNow) void'(mQ.pop_front());
    if (pendV) begin
      if (mChk < CMAX) mChk++;
      if (pend.r0 != pend.ex) begin
        if (mErr < CMAX) mErr++;
        if (mQ.size() < DEPTH) mQ.push_back(pend);
        else mOvf = 1'b1;
      end
    end
    pendV = in_valid;
    pend  = '{op: op, r2: R2, r3: R3, r0: R0, ex: ResultVerify};
  endfunction

  task automatic checkAll();
    rec_t head;
    head = (mQ.size() > 0) ? mQ[0] : '0;
    chkVal("err_valid", 64'(err_valid), 64'(mQ.size() > 0));
    chkVal("err_op",    64'(err_op),    64'(head.op));
    chkVal("err_R2",    64'(err_R2),    64'(head.r2));
    chkVal("err_R3",    64'(err_R3),    64'(head.r3));
    chkVal("err_R0",    64'(err_R0),    64'(head.r0));
    chkVal("err_exp",   64'(err_exp),   64'(head.ex));
    chkVal("check_cnt", 64'(check_cnt), 64'(mChk));
    chkVal("error_cnt", 64'(error_cnt), 64'(mErr));
    chkVal("overflow",  64'(overflow),  64'(mOvf));
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep();
    #1;
    checkAll();
  endtask

  task automatic setIn(input bit v, input logic [2:0] o, input logic [N-1:0] a,
                       input logic [N-1:0] b, input logic [N-1:0] r, input logic [N-1:0] e);
    in_valid     = v;
    op           = o;
    R2           = a;
    R3           = b;
    R0           = r;
    ResultVerify = e;
  endtask

  task automatic idle();
    setIn(1'b0, 3'd0, '0, '0, '0, '0);
  endtask

  task automatic doClear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  int popCnt;

  initial begin
    rst_n     = 1'b0;
    clear     = 1'b0;
    err_ready = 1'b0;
    idle();
    modelReset();
    #1;
    checkAll();
    tick();
    tick();
    rst_n = 1'b1;

    // Pass case: equal result, nothing queued
    setIn(1'b1, 3'b010, 32'd13, 32'd15, 32'd28, 32'd28);
    tick();
    idle();
    tick();
    chkVal("pass_check_cnt", 64'(check_cnt), 64'd1);
    chkVal("pass_error_cnt", 64'(error_cnt), 64'd0);
    chkVal("pass_err_valid", 64'(err_valid), 64'd0);

    // Fail case: record visible two edges after the sample, popped by one ready
    setIn(1'b1, 3'b011, 32'h6AF6095F, 32'h6AF6095F, 32'h1, 32'h0);
    tick();
    idle();
    tick();
    chkVal("fail_err_valid", 64'(err_valid), 64'd1);
    chkVal("fail_err_op",    64'(err_op),    64'd3);
    chkVal("fail_err_R2",    64'(err_R2),    64'h6AF6095F);
    chkVal("fail_err_R0",    64'(err_R0),    64'd1);
    chkVal("fail_err_exp",   64'(err_exp),   64'd0);
    chkVal("fail_error_cnt", 64'(error_cnt), 64'd1);
    err_ready = 1'b1;
    tick();
    err_ready = 1'b0;
    chkVal("fail_popped_valid", 64'(err_valid), 64'd0);
    chkVal("fail_popped_R0",    64'(err_R0),    64'd0);

    // Overflow: five mismatches with no consumer, four survive in order
    doClear();
    for (int i = 0; i < 5; i++) begin
      setIn(1'b1, 3'(i), 32'(i), 32'(i), 32'(100 + i), 32'h0);
      tick();
    end
    idle();
    tick();
    chkVal("ovf_flag",      64'(overflow),  64'd1);
    chkVal("ovf_error_cnt", 64'(error_cnt), 64'd5);
    chkVal("ovf_check_cnt", 64'(check_cnt), 64'd5);
    err_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chkVal("ovf_order", 64'(err_R0), 64'(100 + k));
      tick();
    end
    err_ready = 1'b0;
    chkVal("ovf_drained", 64'(err_valid), 64'd0);

    // Full FIFO with push and pop on the same edge
    doClear();
    for (int i = 0; i < 4; i++) begin
      setIn(1'b1, 3'd1, 32'd7, 32'd9, 32'(200 + i), 32'h0);
      tick();
    end
    setIn(1'b1, 3'd1, 32'd7, 32'd9, 32'd204, 32'h0);
    tick();
    idle();
    err_ready = 1'b1;
    tick();
    err_ready = 1'b0;
    chkVal("full_pp_overflow", 64'(overflow), 64'd0);
    chkVal("full_pp_head",     64'(err_R0),   64'd201);
    popCnt = 0;
    err_ready = 1'b1;
    for (int k = 0; k < 10 && err_valid; k++) begin
      if (k == 3) chkVal("full_pp_last", 64'(err_R0), 64'd204);
      tick();
      popCnt++;
    end
    err_ready = 1'b0;
    chkVal("full_pp_occupancy", 64'(popCnt), 64'd4);

    // Counter saturation at 2^CNT_W-1
    doClear();
    for (int i = 0; i < 17; i++) begin
      setIn(1'b1, 3'd5, 32'(i), 32'(i), 32'hFFFF_FFFF, 32'(i));
      tick();
    end
    idle();
    tick();
    chkVal("sat_check_cnt", 64'(check_cnt), 64'd15);
    chkVal("sat_error_cnt", 64'(error_cnt), 64'd15);

    // Asynchronous reset between edges with records queued
    doClear();
    for (int i = 0; i < 2; i++) begin
      setIn(1'b1, 3'd6, 32'd1, 32'd2, 32'(300 + i), 32'd3);
      tick();
    end
    idle();
    tick();
    tick();
    chkVal("rst_pre_valid", 64'(err_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkAll();
    chkVal("rst_async_valid", 64'(err_valid), 64'd0);
    chkVal("rst_async_err",   64'(error_cnt), 64'd0);
    chkVal("rst_async_R0",    64'(err_R0),    64'd0);
    #1;
    rst_n = 1'b1;
    setIn(1'b1, 3'd0, 32'd4, 32'd4, 32'd8, 32'd8);
    tick();
    idle();
    tick();
    chkVal("rst_first_sample", 64'(check_cnt), 64'd1);

    // Clear concurrent with a mismatching sample: sample discarded
    setIn(1'b1, 3'd2, 32'd1, 32'd1, 32'd5, 32'd6);
    tick();
    setIn(1'b1, 3'd2, 32'd1, 32'd1, 32'd5, 32'd6);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    idle();
    chkVal("clr_check_cnt", 64'(check_cnt), 64'd0);
    chkVal("clr_err_valid", 64'(err_valid), 64'd0);
    tick();
    chkVal("clr_after_chk", 64'(check_cnt), 64'd0);
    chkVal("clr_after_err", 64'(error_cnt), 64'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [N-1:0] e;
      e = N'($urandom);
      setIn($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), N'($urandom), N'($urandom),
            ($urandom_range(0, 1) == 1) ? (e ^ (N'(1) << $urandom_range(0, N - 1))) : e, e);
      err_ready = ($urandom_range(0, 2) == 0);
      clear     = ($urandom_range(0, 49) == 0);
      tick();
    end
    clear     = 1'b0;
    err_ready = 1'b0;
    idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
